instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 tb/tb_instr_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute sequencer owning PC and IR for the 16-bit core.
// Optional handshake-stall watchdog enabled by defining SEQ_WATCHDOG_EN.
module instr_sequencer #(
    parameter int AW         = 10,
    parameter int RESET_PC   = 0,
    parameter int WDOG_LIMIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    output logic [15:0]   ir,
    output logic          exec,
    input  logic          mem_access,
    input  logic          halt_in,
    input  logic          cond_true,
    input  logic [15:0]   jmp_reg,
    output logic          dmem_req,
    input  logic          dmem_ack,
    output logic          wb_en,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DMEM,
        S_HALTED
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [AW-1:0] pc_inc, pc_rel, pc_next;
    logic          unused_jmp;

    assign unused_jmp = ^jmp_reg;

    assign pc_inc = pc_q + AW'(1);
    assign pc_rel = pc_q + {{(AW-6){ir_q[5]}}, ir_q[5:0]};

    always_comb begin
        pc_next = pc_inc;
        case (ir_q[15:12])
            4'h0:    pc_next = jmp_reg[AW-1:0];
            4'h1:    pc_next = pc_rel;
            4'h2:    pc_next = cond_true ? jmp_reg[AW-1:0] : pc_inc;
            4'h3:    pc_next = cond_true ? pc_rel : pc_inc;
            default: pc_next = pc_inc;
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    localparam logic [7:0] WDOG_LIM8 = 8'(WDOG_LIMIT);
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       fault_q, fault_d;
    logic       stall;
`else
    logic [7:0] unused_wdog;
    assign unused_wdog = 8'(WDOG_LIMIT);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wb_en   = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (halt_in) begin
                    state_d = S_HALTED;
                end else if (mem_access) begin
                    state_d = S_DMEM;
                end else begin
                    pc_d    = pc_next;
                    wb_en   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DMEM: begin
                if (dmem_ack) begin
                    wb_en   = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
`ifdef SEQ_WATCHDOG_EN
        // Limit check overrides the next state; the counter then clears on any state change.
        fault_d  = fault_q;
        wd_cnt_d = wd_cnt_q;
        stall    = (state_q == S_FETCH && !imem_ack) || (state_q == S_DMEM && !dmem_ack);
        if (stall && (wd_cnt_q == WDOG_LIM8 - 8'd1)) begin
            fault_d = 1'b1;
            state_d = S_HALTED;
        end
        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end else if (stall) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= AW'(RESET_PC);
            ir_q    <= 16'h7200;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            fault_q  <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign imem_req  = (state_q == S_FETCH);
    assign dmem_req  = (state_q == S_DMEM);
    assign exec      = (state_q == S_EXEC);
    assign halted    = (state_q == S_HALTED);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: bench acting as imem, dmem and decoder around instr_sequencer,
// with an instruction-level PC model.
module tb_instr_sequencer;

    localparam int AW   = 10;
    localparam int PMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;
    logic [15:0]   ir;
    logic          exec;
    logic          mem_access;
    logic          halt_in;
    logic          cond_true;
    logic [15:0]   jmp_reg;
    logic          dmem_req;
    logic          dmem_ack;
    logic          wb_en;
    logic [AW-1:0] pc;
    logic          halted;
    logic          fault;

    int checks = 0;
    int fails  = 0;
    int mpc    = 0;
    int dreq_seen = 0;
    int wb_seen   = 0;

    instr_sequencer #(.AW(AW), .RESET_PC(0), .WDOG_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .exec(exec), .mem_access(mem_access), .halt_in(halt_in),
        .cond_true(cond_true), .jmp_reg(jmp_reg),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .wb_en(wb_en),
        .pc(pc), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_next_pc(input int cur, input logic [15:0] instr,
                                         input logic cond, input logic [15:0] jr);
        int off;
        int tgt;
        off = int'(instr[5:0]);
        if (instr[5]) off = off - 64;
        tgt = int'(jr) % PMOD;
        case (instr[15:12])
            4'h0:    return tgt;
            4'h1:    return ((cur + off) % PMOD + PMOD) % PMOD;
            4'h2:    return cond ? tgt : (cur + 1) % PMOD;
            4'h3:    return cond ? ((cur + off) % PMOD + PMOD) % PMOD : (cur + 1) % PMOD;
            default: return (cur + 1) % PMOD;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        halt_in = 1'b0; mem_access = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        mpc = 0;
    endtask

    // Runs one instruction starting in the FETCH state; bench decode: 0x73FF halts, opcodes 4/5 access memory.
    task automatic do_instr(input logic [15:0] instr, input logic cond, input logic [15:0] jr,
                            input int fwait, input int dwait);
        logic is_halt;
        logic is_mem;
        is_halt = (instr == 16'h73FF);
        is_mem  = (instr[15:12] == 4'h4) || (instr[15:12] == 4'h5);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== AW'(mpc) || pc !== AW'(mpc)) begin
            fails++;
            $display("FAIL fetch_start: req=%b addr=%0d pc=%0d, want req=1 addr/pc=%0d", imem_req, imem_addr, pc, mpc);
        end
        for (int i = 0; i <= fwait; i++) begin
            imem_ack   = (i == fwait);
            imem_rdata = (i == fwait) ? instr : 16'($urandom);
            mem_access = 1'($urandom);
            halt_in    = 1'($urandom);
            #1;
            checks++;
            if (imem_req !== 1'b1 || wb_en !== 1'b0 || exec !== 1'b0 || fault !== 1'b0) begin
                fails++;
                $display("FAIL fetch_wait: req=%b wb=%b exec=%b fault=%b, want 1 0 0 0", imem_req, wb_en, exec, fault);
            end
            step();
        end
        imem_ack   = 1'b0;
        halt_in    = is_halt;
        mem_access = is_mem;
        cond_true  = cond;
        jmp_reg    = jr;
        #1;
        checks++;
        if (exec !== 1'b1 || ir !== instr || imem_req !== 1'b0 || wb_en !== !(is_halt || is_mem)) begin
            fails++;
            $display("FAIL exec_cycle: exec=%b ir=%h req=%b wb=%b, want 1 %h 0 %b", exec, ir, imem_req, wb_en, instr, !(is_halt || is_mem));
        end
        if (wb_en === 1'b1) wb_seen++;
        step();
        halt_in    = 1'b0;
        mem_access = 1'b0;
        if (is_halt) return;
        if (is_mem) begin
            for (int i = 0; i <= dwait; i++) begin
                dmem_ack = (i == dwait);
                #1;
                if (dmem_req === 1'b1) dreq_seen++;
                if (wb_en === 1'b1) wb_seen++;
                checks++;
                if (dmem_req !== 1'b1 || exec !== 1'b0 || wb_en !== (i == dwait) || pc !== AW'(mpc)) begin
                    fails++;
                    $display("FAIL dmem_cycle %0d: dreq=%b exec=%b wb=%b pc=%0d, want 1 0 %b %0d", i, dmem_req, exec, wb_en, pc, (i == dwait), mpc);
                end
                step();
            end
            dmem_ack = 1'b0;
            mpc = (mpc + 1) % PMOD;
        end else begin
            mpc = model_next_pc(mpc, instr, cond, jr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
        halt_in = 1'b0; mem_access = 1'b0; cond_true = 1'b0; jmp_reg = '0;
        step(); step();
        checks++;
        if (imem_req !== 1'b0 || dmem_req !== 1'b0 || exec !== 1'b0 || halted !== 1'b0 ||
            fault !== 1'b0 || wb_en !== 1'b0 || pc !== '0 || ir !== 16'h7200) begin
            fails++;
            $display("FAIL reset_state: req=%b dreq=%b exec=%b halted=%b fault=%b wb=%b pc=%0d ir=%h", imem_req, dmem_req, exec, halted, fault, wb_en, pc, ir);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_req: req=%b want 0", imem_req);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== '0) begin
            fails++;
            $display("FAIL first_fetch: req=%b addr=%0d want 1 0", imem_req, imem_addr);
        end
        mpc = 0;
    endtask

    task automatic test_nop_stream();
        for (int k = 0; k < 3; k++) do_instr(16'h7200, 1'b0, 16'h0, 0, 0);
        checks++;
        if (imem_addr !== 10'd3) begin
            fails++;
            $display("FAIL nop_stream_addr: addr=%0d want 3", imem_addr);
        end
    endtask

    task automatic test_jmpr();
        do_instr(16'h0000, 1'b0, 16'h0005, 0, 0);
        do_instr(16'h103E, 1'b0, 16'($urandom), 1, 0);
        checks++;
        if (imem_addr !== 10'd3) begin
            fails++;
            $display("FAIL jmpr_back: addr=%0d want 3", imem_addr);
        end
        do_instr(16'h0000, 1'b0, 16'h0001, 0, 0);
        do_instr(16'h103E, 1'b0, 16'($urandom), 0, 0);
        checks++;
        if (imem_addr !== 10'd1023) begin
            fails++;
            $display("FAIL jmpr_wrap: addr=%0d want 1023", imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_instr(16'h7200, 1'b0, 16'h0, 0, 0);
        checks++;
        if (imem_addr !== 10'd0) begin
            fails++;
            $display("FAIL pc_wrap: addr=%0d want 0", imem_addr);
        end
    endtask

    task automatic test_jmpcond();
        do_instr(16'h0000, 1'b0, 16'h0010, 0, 0);
        do_instr(16'h2000, 1'b0, 16'h0123, 0, 0);
        checks++;
        if (imem_addr !== 10'h011) begin
            fails++;
            $display("FAIL jmpcond_false: addr=%h want 011", imem_addr);
        end
        do_instr(16'h2000, 1'b1, 16'h0123, 0, 0);
        checks++;
        if (imem_addr !== 10'h123) begin
            fails++;
            $display("FAIL jmpcond_true: addr=%h want 123", imem_addr);
        end
    endtask

    task automatic test_load();
        int start;
        start     = mpc;
        dreq_seen = 0;
        wb_seen   = 0;
        do_instr(16'h4000, 1'b0, 16'h0, 0, 4);
        checks++;
        if (dreq_seen !== 5 || wb_seen !== 1 || imem_addr !== AW'((start + 1) % PMOD)) begin
            fails++;
            $display("FAIL load_stall: dreq_cycles=%0d wb_pulses=%0d addr=%0d, want 5 1 %0d", dreq_seen, wb_seen, imem_addr, (start + 1) % PMOD);
        end
    endtask

    task automatic test_random();
        logic [15:0] instr;
        for (int k = 0; k < 60; k++) begin
            instr = 16'($urandom);
            if (instr == 16'h73FF) instr = 16'h7200;
            do_instr(instr, 1'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_stall_limit();
`ifdef SEQ_WATCHDOG_EN
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (halted !== 1'b0 || fault !== 1'b0 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL wdog_early: halted=%b fault=%b req=%b want 0 0 1", halted, fault, imem_req);
        end
        step();
        checks++;
        if (halted !== 1'b1 || fault !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL wdog_trip: halted=%b fault=%b req=%b want 1 1 0", halted, fault, imem_req);
        end
        do_reset();
        do_instr(16'h7200, 1'b0, 16'h0, 3, 0);
        checks++;
        if (fault !== 1'b0 || halted !== 1'b0) begin
            fails++;
            $display("FAIL wdog_ack_wins: fault=%b halted=%b want 0 0", fault, halted);
        end
`else
        do_instr(16'h7200, 1'b0, 16'h0, 30, 0);
        do_instr(16'h5000, 1'b0, 16'h0, 0, 30);
        checks++;
        if (fault !== 1'b0 || halted !== 1'b0) begin
            fails++;
            $display("FAIL long_stall: fault=%b halted=%b want 0 0", fault, halted);
        end
`endif
    endtask

    task automatic test_reset_midhandshake();
        do_reset();
        imem_ack = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL async_req_drop: req=%b want 0", imem_req);
        end
        step();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1234;
        step();
        checks++;
        if (ir !== 16'h7200 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL idle_ack_ignored: ir=%h req=%b want 7200 1", ir, imem_req);
        end
        imem_ack = 1'b0;
        mpc = 0;
        do_instr(16'h7200, 1'b0, 16'h0, 0, 0);
    endtask

    task automatic test_halt();
        int hpc;
        hpc = mpc;
        do_instr(16'h73FF, 1'b0, 16'h0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom);
            dmem_ack = 1'($urandom);
            #1;
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0 || exec !== 1'b0 ||
                wb_en !== 1'b0 || pc !== AW'(hpc)) begin
                fails++;
                $display("FAIL halted_cycle %0d: halted=%b req=%b dreq=%b exec=%b wb=%b pc=%0d", i, halted, imem_req, dmem_req, exec, wb_en, pc);
            end
            step();
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        do_reset();
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== '0 || ir !== 16'h7200) begin
            fails++;
            $display("FAIL halt_reset: halted=%b req=%b addr=%0d ir=%h want 0 1 0 7200", halted, imem_req, imem_addr, ir);
        end
        do_instr(16'h7200, 1'b0, 16'h0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_jmpr();
        test_wrap();
        test_jmpcond();
        test_load();
        test_random();
        test_stall_limit();
        test_reset_midhandshake();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
